// File: rtl/pmp_phase_packetizer_if.sv
// pmp_phase_packetizer_if: input/output AXI-Stream bundle of the phase packetizer.
// slave is the packetizer side, master the upstream/downstream environment side.
interface pmp_phase_packetizer_if #(
    parameter int PHASE_NUM  = 8,
    parameter int DATA_WIDTH = 16
);
    localparam int W = PHASE_NUM * DATA_WIDTH;
    logic [W-1:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [W-1:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [1:0]   m_axis_tuser;
    logic         frame_done;
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, frame_done
    );
    modport master (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, frame_done
    );
endinterface

// File: rtl/pmp_phase_packetizer.sv
// pmp_phase_packetizer: cuts a phase beat stream into PACKAGE_LEN-beat packets tagged 0,1,2 on tuser,
// with GAP_CYCLES of input back-pressure after each packet and a frame_done pulse per index-2 packet.
module pmp_phase_packetizer #(
    parameter int PHASE_NUM   = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int PACKAGE_LEN = 256,
    parameter int GAP_CYCLES  = 10
) (
    input logic aclk,
    input logic aresetn,
    pmp_phase_packetizer_if.slave bus
);
    localparam int W  = PHASE_NUM * DATA_WIDTH;
    localparam int BW = $clog2(PACKAGE_LEN);
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
    typedef enum logic {SEND, GAP} state_t;
    state_t        state;
    logic [BW-1:0] beat_cnt;
    logic [GW-1:0] gap_cnt;
    logic [1:0]    freq_idx;
    logic [W-1:0]  tdata;
    logic          tvalid;
    logic          tlast;
    logic [1:0]    tuser;
    logic          done;
    logic          ready;
    logic          accept;
    logic          last_beat;
    assign ready     = state == SEND && (!tvalid || bus.m_axis_tready);
    assign accept    = bus.s_axis_tvalid && ready;
    assign last_beat = beat_cnt == BW'(PACKAGE_LEN - 1);
    assign bus.s_axis_tready = ready;
    assign bus.m_axis_tdata  = tdata;
    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tlast  = tlast;
    assign bus.m_axis_tuser  = tuser;
    assign bus.frame_done    = done;
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= SEND;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            freq_idx <= 2'd0;
            tdata    <= '0;
            tvalid   <= 1'b0;
            tlast    <= 1'b0;
            tuser    <= 2'd0;
            done     <= 1'b0;
        end else begin
            done <= tvalid && bus.m_axis_tready && tlast && tuser == 2'd2;
            if (accept) begin
                tdata  <= bus.s_axis_tdata;
                tlast  <= last_beat;
                tuser  <= freq_idx;
                tvalid <= 1'b1;
            end else if (bus.m_axis_tready) begin
                tvalid <= 1'b0;
            end
            if (state == SEND) begin
                if (accept) begin
                    beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                    if (last_beat) begin
                        freq_idx <= freq_idx == 2'd2 ? 2'd0 : freq_idx + 2'd1;
                        // with no gap configured the next packet follows back-to-back
                        if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end
                    end
                end
            end else begin
                gap_cnt <= gap_cnt + 1'b1;
                if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= SEND;
            end
        end
    end
endmodule

// File: tb/tb_pmp_phase_packetizer.sv
// tb_pmp_phase_packetizer: scoreboard bench; accepted input beats are tagged by a packet-count model
// and queued, a monitor pops and compares every output handshake.
module tb_pmp_phase_packetizer;
    localparam int W   = 128;
    localparam int PL  = 256;
    localparam int GAP = 10;
    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
        logic [1:0]   u;
    } beat_t;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;
    pmp_phase_packetizer_if #(.PHASE_NUM(8), .DATA_WIDTH(16)) bus ();
    pmp_phase_packetizer_if #(.PHASE_NUM(8), .DATA_WIDTH(16)) bus0 ();
    pmp_phase_packetizer #(.PHASE_NUM(8), .DATA_WIDTH(16), .PACKAGE_LEN(PL), .GAP_CYCLES(GAP)) dut (
        .aclk(aclk), .aresetn(aresetn), .bus(bus)
    );
    pmp_phase_packetizer #(.PHASE_NUM(8), .DATA_WIDTH(16), .PACKAGE_LEN(PL), .GAP_CYCLES(0)) dut0 (
        .aclk(aclk), .aresetn(aresetn), .bus(bus0)
    );
    int checks = 0;
    int errors = 0;
    beat_t q[$];
    beat_t q0[$];
    beat_t e_m, e0, held;
    int k, k0, low_run, fd_count, fd0_count, drops0;
    bit fd_exp, nxt_fd, stall, gap_armed, chk_gap, scen3;
    // beat number idx since reset fixes its packet, position and tag
    function automatic beat_t model(int idx, logic [W-1:0] d);
        beat_t b;
        b.d = d;
        b.l = (idx % PL) == PL - 1;
        b.u = 2'((idx / PL) % 3);
        return b;
    endfunction
    function automatic logic [W-1:0] pick(int i, int mode);
        logic [15:0] v;
        if (mode <= 2) begin
            v = (i / PL) % 3 == 0 ? 16'h53A1 : (i / PL) % 3 == 1 ? 16'h2249 : 16'h432A;
            return {8{v}};
        end
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    task automatic chk(string nm, logic [135:0] act, logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask
    always @(negedge aclk) begin
        if (!aresetn) begin
            q.delete();
            k = 0;
            fd_exp = 0;
            stall = 0;
            gap_armed = 0;
        end else begin
            if (fd_exp || bus.frame_done) chk("frame_done", 136'(bus.frame_done), 136'(fd_exp));
            if (bus.frame_done) fd_count++;
            if (stall)
                chk("stall_hold", {bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser},
                    {1'b1, held});
            nxt_fd = 0;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat act=%0h exp=none", bus.m_axis_tdata);
                end else begin
                    e_m = q.pop_front();
                    chk("beat", {bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser}, e_m);
                    nxt_fd = e_m.l && e_m.u == 2'd2;
                end
            end
            stall = bus.m_axis_tvalid && !bus.m_axis_tready;
            held = {bus.m_axis_tdata, bus.m_axis_tlast, bus.m_axis_tuser};
            fd_exp = nxt_fd;
            if (gap_armed) begin
                if (!bus.s_axis_tready) low_run++;
                else begin
                    if (chk_gap) chk("gap_len", 136'(low_run), 136'(GAP));
                    gap_armed = 0;
                end
            end
            if (bus.s_axis_tvalid && bus.s_axis_tready) begin
                e_m = model(k, bus.s_axis_tdata);
                q.push_back(e_m);
                if (e_m.l) begin
                    gap_armed = 1;
                    low_run = 0;
                end
                k++;
            end
        end
    end
    always @(negedge aclk) begin
        if (!aresetn) begin
            q0.delete();
            k0 = 0;
        end else begin
            if (bus0.frame_done) fd0_count++;
            if (scen3 && !bus0.s_axis_tready) drops0++;
            if (bus0.m_axis_tvalid && bus0.m_axis_tready) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat0 act=%0h exp=none", bus0.m_axis_tdata);
                end else begin
                    e0 = q0.pop_front();
                    chk("beat0", {bus0.m_axis_tdata, bus0.m_axis_tlast, bus0.m_axis_tuser}, e0);
                end
            end
            if (bus0.s_axis_tvalid && bus0.s_axis_tready) begin
                q0.push_back(model(k0, bus0.s_axis_tdata));
                k0++;
            end
        end
    end
    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask
    task automatic drive(input bit sel, input int n, input int mode);
        int i = 0;
        int cyc = 0;
        int w = 0;
        bit hs;
        logic [W-1:0] d;
        d = pick(0, mode);
        while (i < n && cyc < 20 * n + 100) begin
            if (sel) begin
                bus0.s_axis_tvalid = 1'b1;
                bus0.s_axis_tdata = d;
            end else begin
                bus.s_axis_tvalid = w == 0;
                bus.s_axis_tdata = d;
                if (mode == 2) bus.m_axis_tready = 1'($urandom_range(0, 1));
            end
            @(negedge aclk);
            hs = sel ? bus0.s_axis_tvalid && bus0.s_axis_tready : bus.s_axis_tvalid && bus.s_axis_tready;
            @(posedge aclk);
            #1;
            cyc++;
            if (hs) begin
                i++;
                d = pick(i, mode);
                if (mode == 4) w = 2;
            end else if (w > 0) w--;
        end
        bus.s_axis_tvalid = 1'b0;
        bus0.s_axis_tvalid = 1'b0;
        bus.m_axis_tready = 1'b1;
        if (i < n) begin
            checks++;
            errors++;
            $display("FAIL drive_timeout sent=%0d need=%0d", i, n);
        end
    endtask
    initial begin
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata = '0;
        bus.m_axis_tready = 1'b1;
        bus0.s_axis_tvalid = 1'b0;
        bus0.s_axis_tdata = '0;
        bus0.m_axis_tready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk("reset_out", {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tdata, bus.frame_done}, '0);
        chk("reset_ready", 136'(bus.s_axis_tready), 136'(1));
        @(posedge aclk);
        #1 aresetn = 1'b1;
        chk_gap = 1;
        drive(0, 3 * PL, 1);
        idle(20);
        chk("fd_count_s1", 136'(fd_count), 136'(1));
        chk_gap = 0;
        drive(0, 3 * PL, 2);
        idle(20);
        scen3 = 1;
        drive(1, 6 * PL, 3);
        idle(5);
        scen3 = 0;
        chk("gap0_drops", 136'(drops0), 136'(0));
        chk("gap0_frame_done", 136'(fd0_count), 136'(2));
        chk("gap0_drain", 136'(q0.size()), 136'(0));
        chk_gap = 1;
        drive(0, 2 * PL, 4);
        idle(20);
        drive(0, PL + 100, 5);
        aresetn = 1'b0;
        @(posedge aclk);
        #1 aresetn = 1'b1;
        @(negedge aclk);
        chk("mid_reset_out", {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser, bus.m_axis_tdata, bus.frame_done}, '0);
        @(posedge aclk);
        #1;
        drive(0, PL, 5);
        idle(20);
        chk("final_drain", 136'(q.size()), 136'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
